// File: rtl/key_event_pkg.sv
// key_event_pkg: key codes, sizes and enqueue priority shared by the key event queue.
package key_event_pkg;
  localparam int NUM_KEYS = 7;
  localparam int KEY_CODE_W = 3;
  typedef enum logic [KEY_CODE_W-1:0] {
    KEY_A, KEY_B, KEY_C, KEY_D, KEY_E, KEY_SPACE, KEY_ESC
  } key_code_e;
  localparam key_code_e PRIO_ORDER [NUM_KEYS] = '{
    KEY_ESC, KEY_SPACE, KEY_A, KEY_B, KEY_C, KEY_D, KEY_E
  };
  // Walk from lowest to highest priority so the last match wins.
  function automatic logic [KEY_CODE_W-1:0] pick_key(input logic [NUM_KEYS-1:0] pend);
    pick_key = KEY_A;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (pend[PRIO_ORDER[i]]) pick_key = PRIO_ORDER[i];
  endfunction
endpackage

// File: rtl/key_event_fifo.sv
// key_event_fifo: small synchronous FIFO of key codes with occupancy count and a
// flush-and-write used when ESC discards the queue.
module key_event_fifo
  import key_event_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_push,
  input  logic [KEY_CODE_W-1:0]   i_data,
  input  logic                    i_pop,
  input  logic                    i_flush,
  output logic                    o_valid,
  output logic                    o_full,
  output logic [KEY_CODE_W-1:0]   o_data,
  output logic [$clog2(DEPTH):0]  o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [KEY_CODE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic w_push, w_pop;
  assign o_valid = r_count != '0;
  assign o_full  = r_count == CW'(DEPTH);
  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;
  assign w_pop   = i_pop & o_valid;
  assign w_push  = i_push & (!o_full | w_pop);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_mem[0] <= i_data;
      r_wr     <= AW'(1);
      r_rd     <= '0;
      r_count  <= CW'(1);
    end else begin
      if (w_push) r_mem[r_wr] <= i_data;
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/key_event_queue.sv
// key_event_queue: turns held-key levels into single press events with per-key
// holdoff and queues them for a valid/ready consumer. ESC_FLUSH_EN: ESC discards the queue.
module key_event_queue
  import key_event_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int HOLDOFF_CYCLES = 1000000,
  parameter int HOLDOFF_WIDTH  = 20
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic                         A,
  input  logic                         B,
  input  logic                         C,
  input  logic                         D,
  input  logic                         E,
  input  logic                         spacebar,
  input  logic                         esc,
  output logic                         ev_valid,
  output logic [KEY_CODE_W-1:0]        ev_code,
  input  logic                         ev_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow
);
  logic [NUM_KEYS-1:0] w_level, w_rise, w_idle, w_accept, w_drop, w_clear;
  logic [NUM_KEYS-1:0] r_prev, r_pending;
  logic [NUM_KEYS-1:0][HOLDOFF_WIDTH-1:0] r_hold;
  logic [KEY_CODE_W-1:0] w_code;
  logic w_push, w_pop, w_full, w_flush, r_overflow;
  assign w_level = {esc, spacebar, E, D, C, B, A};
  assign w_rise  = w_level & ~r_prev;
  // A rise outside holdoff with the key already pending has nowhere to go.
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    assign w_idle[k]   = r_hold[k] == '0;
    assign w_accept[k] = w_rise[k] & w_idle[k] & ~r_pending[k];
    assign w_drop[k]   = w_rise[k] & w_idle[k] & r_pending[k];
  end
  assign w_code  = pick_key(r_pending);
  assign w_pop   = ev_valid & ev_ready;
  assign w_push  = |r_pending & (!w_full | w_pop);
  assign w_clear = w_push ? NUM_KEYS'(1) << w_code : '0;
`ifdef ESC_FLUSH_EN
  assign w_flush = w_push & (w_code == KEY_ESC);
`else
  assign w_flush = 1'b0;
`endif
  assign overflow = r_overflow;
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_prev     <= '1;
      r_pending  <= '0;
      r_hold     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_prev     <= w_level;
      r_pending  <= (w_flush ? '0 : r_pending & ~w_clear) | w_accept;
      r_overflow <= |w_drop;
      for (int i = 0; i < NUM_KEYS; i++)
        r_hold[i] <= (w_rise[i] && w_idle[i]) ? HOLDOFF_WIDTH'(HOLDOFF_CYCLES)
                   : w_idle[i] ? r_hold[i] : r_hold[i] - HOLDOFF_WIDTH'(1);
    end
  end
  key_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .i_push  (w_push),
    .i_data  (w_code),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_valid (ev_valid),
    .o_full  (w_full),
    .o_data  (ev_code),
    .o_count (fifo_count)
  );
endmodule

// File: tb/tb_key_event_queue.sv
// tb_key_event_queue: directed scenarios for the key event queue with
// HOLDOFF_CYCLES=8 and FIFO_DEPTH=4.
module tb_key_event_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] keys = '0;
  logic ev_ready = 1'b0;
  logic ev_valid, overflow;
  logic [2:0] ev_code;
  logic [2:0] fifo_count;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  key_event_queue #(.FIFO_DEPTH(4), .HOLDOFF_CYCLES(8), .HOLDOFF_WIDTH(4)) dut (
    .CLK        (clk),
    .RESET_N    (rst_n),
    .A          (keys[0]),
    .B          (keys[1]),
    .C          (keys[2]),
    .D          (keys[3]),
    .E          (keys[4]),
    .spacebar   (keys[5]),
    .esc        (keys[6]),
    .ev_valid   (ev_valid),
    .ev_code    (ev_code),
    .ev_ready   (ev_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    keys = '0;
    ev_ready = 1'b0;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic fill(input int n);
    for (int k = 0; k < n; k++) begin
      keys[k] = 1'b1;
      tick(1);
      keys[k] = 1'b0;
      tick(1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", ev_valid); end
    total++; if (ev_code !== 3'd0) begin bad++; $display("FAIL reset_code got=%0d want=0", ev_code); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0b want=0", overflow); end
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_single();
    do_reset();
    keys[0] = 1'b1;
    tick(1);
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%0b want=0", ev_valid); end
    tick(1);
    total++; if (ev_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b want=1", ev_valid); end
    total++; if (ev_code !== 3'd0) begin bad++; $display("FAIL single_code got=%0d want=0", ev_code); end
    tick(1);
    keys[0] = 1'b0;
    tick(2);
    total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL single_count got=%0d want=1", fifo_count); end
    ev_ready = 1'b1;
    tick(1);
    ev_ready = 1'b0;
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL single_pop_count got=%0d want=0", fifo_count); end
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL single_pop_valid got=%0b want=0", ev_valid); end
  endtask

  task automatic test_holdoff();
    do_reset();
    keys[2] = 1'b1;
    tick(1);
    keys[2] = 1'b0;
    tick(3);
    keys[2] = 1'b1;
    tick(1);
    keys[2] = 1'b0;
    tick(4);
    total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL holdoff_one_event got=%0d want=1", fifo_count); end
    total++; if (ev_code !== 3'd2) begin bad++; $display("FAIL holdoff_code got=%0d want=2", ev_code); end
    keys[2] = 1'b1;
    tick(1);
    keys[2] = 1'b0;
    tick(1);
    total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL holdoff_second_event got=%0d want=2", fifo_count); end
    ev_ready = 1'b1;
    tick(1);
    total++; if (ev_code !== 3'd2) begin bad++; $display("FAIL holdoff_second_code got=%0d want=2", ev_code); end
    tick(1);
    ev_ready = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    keys = 7'b110_0010;
    tick(1);
    keys = '0;
    tick(1);
    total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL simul_count1 got=%0d want=1", fifo_count); end
    total++; if (ev_code !== 3'd6) begin bad++; $display("FAIL simul_head got=%0d want=6", ev_code); end
    tick(2);
    total++; if (fifo_count !== 3'd3) begin bad++; $display("FAIL simul_count3 got=%0d want=3", fifo_count); end
    ev_ready = 1'b1;
    tick(1);
    total++; if (ev_code !== 3'd5) begin bad++; $display("FAIL simul_second got=%0d want=5", ev_code); end
    tick(1);
    total++; if (ev_code !== 3'd1) begin bad++; $display("FAIL simul_third got=%0d want=1", ev_code); end
    tick(1);
    ev_ready = 1'b0;
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL simul_drained got=%0d want=0", fifo_count); end
  endtask

  task automatic test_full_overflow();
    do_reset();
    fill(5);
    total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d want=4", fifo_count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_no_overflow got=%0b want=0", overflow); end
    tick(8);
    keys[4] = 1'b1;
    tick(1);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL overflow_pulse got=%0b want=1", overflow); end
    keys[4] = 1'b0;
    tick(1);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL overflow_one_cycle got=%0b want=0", overflow); end
    ev_ready = 1'b1;
    tick(1);
    ev_ready = 1'b0;
    total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL overflow_pop_count got=%0d want=4", fifo_count); end
    total++; if (ev_code !== 3'd1) begin bad++; $display("FAIL overflow_pop_head got=%0d want=1", ev_code); end
    ev_ready = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      tick(1);
      total++; if (ev_code !== 3'(i)) begin bad++; $display("FAIL overflow_order[%0d] got=%0d want=%0d", i, ev_code, i); end
    end
    tick(1);
    ev_ready = 1'b0;
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL overflow_drained got=%0d want=0", fifo_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    fill(5);
    ev_ready = 1'b1;
    total++; if (ev_code !== 3'd0) begin bad++; $display("FAIL b2b_head got=%0d want=0", ev_code); end
    tick(1);
    total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL b2b_count got=%0d want=4", fifo_count); end
    for (int i = 1; i <= 4; i++) begin
      total++; if (ev_code !== 3'(i)) begin bad++; $display("FAIL b2b_order[%0d] got=%0d want=%0d", i, ev_code, i); end
      tick(1);
    end
    ev_ready = 1'b0;
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL b2b_drained got=%0d want=0", fifo_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    fill(2);
    keys[3] = 1'b1;
    tick(1);
    rst_n = 1'b0;
    #1;
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL midreset_count got=%0d want=0", fifo_count); end
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid got=%0b want=0", ev_valid); end
    tick(2);
    rst_n = 1'b1;
    tick(3);
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL held_through_reset got=%0d want=0", fifo_count); end
    keys[3] = 1'b0;
    tick(1);
    keys[3] = 1'b1;
    tick(1);
    keys[3] = 1'b0;
    tick(1);
    total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL repress_count got=%0d want=1", fifo_count); end
    total++; if (ev_code !== 3'd3) begin bad++; $display("FAIL repress_code got=%0d want=3", ev_code); end
  endtask

  task automatic test_esc_flush();
    do_reset();
    fill(3);
    total++; if (fifo_count !== 3'd3) begin bad++; $display("FAIL flush_pre_count got=%0d want=3", fifo_count); end
    keys[6] = 1'b1;
    tick(1);
    keys[6] = 1'b0;
    tick(1);
    total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL flush_count got=%0d want=1", fifo_count); end
    total++; if (ev_code !== 3'd6) begin bad++; $display("FAIL flush_code got=%0d want=6", ev_code); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_holdoff();
`ifdef ESC_FLUSH_EN
    test_esc_flush();
`else
    test_simultaneous();
`endif
    test_full_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
